// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if: pixel request, returned colour and aligned VGA output bundle
interface vga_timing_pipe_if #(
  parameter int RW = 3,
  parameter int GW = 3,
  parameter int BW = 2,
  parameter int OUT_W = 4
);
  logic en;
  logic [RW-1:0] in_red;
  logic [GW-1:0] in_green;
  logic [BW-1:0] in_blue;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic req_valid;
  logic line_start;
  logic frame_start;
  logic hsync;
  logic vsync;
  logic de;
  logic [OUT_W-1:0] red;
  logic [OUT_W-1:0] green;
  logic [OUT_W-1:0] blue;
  modport master (
    input en, in_red, in_green, in_blue,
    output req_x, req_y, req_valid, line_start, frame_start, hsync, vsync, de, red, green, blue
  );
  modport slave (
    output en, in_red, in_green, in_blue,
    input req_x, req_y, req_valid, line_start, frame_start, hsync, vsync, de, red, green, blue
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA timing with latency-matched pixel requests and colour width expansion
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int RW = 3,
  parameter int GW = 3,
  parameter int BW = 2,
  parameter int OUT_W = 4,
  parameter int LAT = 2
) (
  input logic vgaclk,
  input logic rst_n,
  vga_timing_pipe_if.master bus
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HL = 11'(HT - 1);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VL = 11'(VT - 1);
  localparam logic [2:0] IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};
  if (LAT < 0 || LAT > 7 || OUT_W < 1 || OUT_W > 8 || RW < 1 || GW < 1 || BW < 1 || HT > 1024 || VT > 1024) begin : g_bad
    $error("vga_timing_pipe: illegal parameter combination");
  end
  logic [9:0] hc;
  logic [9:0] vc;
  logic [10:0] hx;
  logic [10:0] vx;
  logic [2:0] cur;
  logic [2:0] tap;
  logic [OUT_W-1:0] xr;
  logic [OUT_W-1:0] xg;
  logic [OUT_W-1:0] xb;
  assign hx = {1'b0, hc};
  assign vx = {1'b0, vc};
  assign bus.req_valid = hx < HA && vx < VA;
  assign bus.req_x = bus.req_valid ? hc : '0;
  assign bus.req_y = bus.req_valid ? vc : '0;
  assign bus.line_start = bus.en && hc == '0;
  assign bus.frame_start = bus.line_start && vc == '0;
  assign cur = {(hx >= HS0 && hx < HS1) ? HSYNC_POL : ~HSYNC_POL,
                (vx >= VS0 && vx < VS1) ? VSYNC_POL : ~VSYNC_POL,
                bus.req_valid};
  // pixel and line counters; the line counter steps on the pixel wrap
  always_ff @(posedge vgaclk)
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (bus.en) begin
      hc <= hx == HL ? '0 : hc + 10'd1;
      if (hx == HL) vc <= vx == VL ? '0 : vc + 10'd1;
    end
  if (LAT == 0) begin : g_nodly
    assign tap = cur;
  end else begin : g_dly
    logic [LAT-1:0][2:0] d;
    // sync/de delay line matching the pixel source latency
    always_ff @(posedge vgaclk)
      if (!rst_n) d <= {LAT{IDLE}};
      else if (bus.en) begin
        d[0] <= cur;
        for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
      end
    assign tap = d[LAT-1];
  end
  for (genvar i = 0; i < OUT_W; i++) begin : g_x
    assign xr[OUT_W-1-i] = bus.in_red[RW-1-(i % RW)];
    assign xg[OUT_W-1-i] = bus.in_green[GW-1-(i % GW)];
    assign xb[OUT_W-1-i] = bus.in_blue[BW-1-(i % BW)];
  end
  // output register pairs delayed sync/de with the colour returned for that pixel
  always_ff @(posedge vgaclk)
    if (!rst_n) begin
      {bus.hsync, bus.vsync, bus.de} <= IDLE;
      bus.red <= '0;
      bus.green <= '0;
      bus.blue <= '0;
    end else if (bus.en) begin
      {bus.hsync, bus.vsync, bus.de} <= tap;
      bus.red <= tap[0] ? xr : '0;
      bus.green <= tap[0] ? xg : '0;
      bus.blue <= tap[0] ? xb : '0;
    end
endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: directed checks of timing, alignment, stall, reset and colour expansion
module tb_vga_timing_pipe;
  logic vgaclk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  bit ok;
  always #5 vgaclk = ~vgaclk;
  vga_timing_pipe_if bus0 ();
  vga_timing_pipe_if bus1 ();
  vga_timing_pipe_if #(.RW(8)) bus2 ();
  vga_timing_pipe u0 (.vgaclk(vgaclk), .rst_n(rst_n), .bus(bus0));
  vga_timing_pipe #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HSYNC_POL(1'b1)) u1 (.vgaclk(vgaclk), .rst_n(rst_n), .bus(bus1));
  vga_timing_pipe #(.RW(8), .LAT(0)) u2 (.vgaclk(vgaclk), .rst_n(rst_n), .bus(bus2));
  // two-stage pixel source for u0: colour = (x[2:0], y[2:0], 2'b10), held while stalled
  logic [2:0] sx [2];
  logic [2:0] sy [2];
  always @(posedge vgaclk)
    if (bus0.en) begin
      sx[0] <= bus0.req_x[2:0];
      sx[1] <= sx[0];
      sy[0] <= bus0.req_y[2:0];
      sy[1] <= sy[0];
    end
  assign bus0.in_red = sx[1];
  assign bus0.in_green = sy[1];
  assign bus0.in_blue = 2'b10;
  assign bus1.in_red = 3'b111;
  assign bus1.in_green = 3'b000;
  assign bus1.in_blue = 2'b01;
  assign bus2.in_red = bus2.req_x == 10'd0 ? 8'hA7 : 8'h53;
  assign bus2.in_green = 3'b101;
  assign bus2.in_blue = 2'b11;

  typedef struct {
    int x;
    int y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  task automatic wait_req0(input int x, input int y, output bit found);
    found = 0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge vgaclk);
      found = bus0.req_valid && bus0.req_x == 10'(x) && bus0.req_y == 10'(y);
    end
    if (!found) timeout($sformatf("wait_req(%0d,%0d)", x, y));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{7,   0, 4'b1111, 4'b0000, 4'b1010},
      '{12,  0, 4'b1001, 4'b0000, 4'b1010},
      '{639, 0, 4'b1111, 4'b0000, 4'b1010},
      '{2,   1, 4'b0100, 4'b0010, 4'b1010},
      '{5,   3, 4'b1011, 4'b0110, 4'b1010},
      '{14,  3, 4'b1101, 4'b0110, 4'b1010},
      '{4,   4, 4'b1001, 4'b1001, 4'b1010}
    };
    rst_n = 1'b0;
    bus0.en = 1'b1;
    bus1.en = 1'b1;
    bus2.en = 1'b1;
    repeat (3) @(posedge vgaclk);
    @(negedge vgaclk);
    chk("rst frame_start", bus0.frame_start, 1);
    chk("rst line_start", bus0.line_start, 1);
    chk("rst req_valid", bus0.req_valid, 1);
    chk("rst req_xy", {bus0.req_x, bus0.req_y}, 0);
    chk("rst hsync", bus0.hsync, 1);
    chk("rst vsync", bus0.vsync, 1);
    chk("rst de", bus0.de, 0);
    chk("rst rgb", {bus0.red, bus0.green, bus0.blue}, 0);
    chk("u2 rst de", bus2.de, 0);
    rst_n = 1'b1;
    bus0.en = 1'b0;
    #1;
    chk("stall frame_start", bus0.frame_start, 0);
    chk("stall line_start", bus0.line_start, 0);
    bus0.en = 1'b1;
    @(negedge vgaclk);
    chk("c1 req_x", bus0.req_x, 1);
    chk("c1 frame_start", bus0.frame_start, 0);
    chk("c1 de", bus0.de, 0);
    chk("u2 c1 de", bus2.de, 1);
    chk("u2 c1 red", bus2.red, 4'hA);
    chk("u2 c1 green", bus2.green, 4'b1011);
    chk("u2 c1 blue", bus2.blue, 4'b1111);
    @(negedge vgaclk);
    chk("c2 de", bus0.de, 0);
    chk("u2 c2 red", bus2.red, 4'h5);
    @(negedge vgaclk);
    chk("c3 de", bus0.de, 1);
    chk("c3 rgb", {bus0.red, bus0.green, bus0.blue}, {4'b0000, 4'b0000, 4'b1010});
    for (int i = 0; i < 7; i++) begin
      wait_req0(tbl[i].x, tbl[i].y, ok);
      if (ok) begin
        repeat (3) @(negedge vgaclk);
        chk($sformatf("vec%0d de", i), bus0.de, 1);
        chk($sformatf("vec%0d hsync", i), bus0.hsync, 1);
        chk($sformatf("vec%0d red", i), bus0.red, tbl[i].r);
        chk($sformatf("vec%0d green", i), bus0.green, tbl[i].g);
        chk($sformatf("vec%0d blue", i), bus0.blue, tbl[i].b);
      end
    end
    wait_req0(0, 5, ok);
    if (ok) begin
      int hs_low, vs_low, de_cnt;
      hs_low = 0;
      vs_low = 0;
      de_cnt = 0;
      repeat (2) @(negedge vgaclk);
      for (int n = 0; n < 800; n++) begin
        @(negedge vgaclk);
        hs_low += int'(!bus0.hsync);
        vs_low += int'(!bus0.vsync);
        de_cnt += int'(bus0.de);
      end
      chk("line hsync low", hs_low, 96);
      chk("line vsync low", vs_low, 0);
      chk("line de", de_cnt, 640);
    end
    wait_req0(100, 6, ok);
    if (ok) begin
      bus0.en = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(negedge vgaclk);
        chk("hold req_x", bus0.req_x, 100);
        chk("hold de", bus0.de, 1);
        chk("hold red", bus0.red, 4'b0010);
        chk("hold green", bus0.green, 4'b1101);
      end
      bus0.en = 1'b1;
      @(negedge vgaclk);
      chk("resume req_x", bus0.req_x, 101);
      chk("resume red", bus0.red, 4'b0100);
    end
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge vgaclk);
      ok = bus1.frame_start;
    end
    if (!ok) timeout("u1 frame_start");
    else begin
      repeat (3) @(negedge vgaclk);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("u1 hc%0d hsync", k), bus1.hsync, k == 5 || k == 6);
        chk($sformatf("u1 hc%0d vsync", k), bus1.vsync, 1);
        chk($sformatf("u1 hc%0d de", k), bus1.de, k < 4);
        chk($sformatf("u1 hc%0d red", k), bus1.red, k < 4 ? 4'b1111 : 4'b0000);
        chk($sformatf("u1 hc%0d blue", k), bus1.blue, k < 4 ? 4'b0101 : 4'b0000);
        @(negedge vgaclk);
      end
    end
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge vgaclk);
      ok = bus1.frame_start;
    end
    if (!ok) timeout("u1 frame_start 2");
    else begin
      int hs_hi, vs_low, de_cnt, ls_cnt, fs_cnt;
      hs_hi = 0;
      vs_low = 0;
      de_cnt = 0;
      ls_cnt = 0;
      fs_cnt = 0;
      for (int n = 0; n < 48; n++) begin
        @(negedge vgaclk);
        hs_hi += int'(bus1.hsync);
        vs_low += int'(!bus1.vsync);
        de_cnt += int'(bus1.de);
        ls_cnt += int'(bus1.line_start);
        fs_cnt += int'(bus1.frame_start);
      end
      chk("u1 frame period", bus1.frame_start, 1);
      chk("u1 frame_start count", fs_cnt, 1);
      chk("u1 line_start count", ls_cnt, 6);
      chk("u1 hsync high", hs_hi, 12);
      chk("u1 vsync low", vs_low, 8);
      chk("u1 de count", de_cnt, 12);
    end
    wait_req0(300, 7, ok);
    if (ok) begin
      rst_n = 1'b0;
      @(negedge vgaclk);
      chk("mid rst hsync", bus0.hsync, 1);
      chk("mid rst vsync", bus0.vsync, 1);
      chk("mid rst de", bus0.de, 0);
      chk("mid rst rgb", {bus0.red, bus0.green, bus0.blue}, 0);
      chk("mid rst req_xy", {bus0.req_x, bus0.req_y}, 0);
      chk("mid rst frame_start", bus0.frame_start, 1);
      rst_n = 1'b1;
      @(negedge vgaclk);
      chk("post rst req_x", bus0.req_x, 1);
      chk("post rst frame_start", bus0.frame_start, 0);
      chk("post rst de1", bus0.de, 0);
      @(negedge vgaclk);
      chk("post rst de2", bus0.de, 0);
      @(negedge vgaclk);
      chk("post rst de3", bus0.de, 1);
      chk("post rst blue", bus0.blue, 4'b1010);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
